// File: rtl/online_to_binary.sv
// online_to_binary: digit-serial signed-digit to two's-complement converter.
// MSD-first on-the-fly conversion using Q/QM registers, no carry chain.
module online_to_binary #(
    parameter  int no_of_digits = 4,
    parameter  int radix_bits   = 3,
    parameter  int radix        = 4,
    parameter  int log_radix    = 2,
    localparam int W            = no_of_digits * log_radix + 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [no_of_digits*radix_bits-1:0] x_in,
    input  logic                               in_neg,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [W-1:0]                       result,
    output logic                               digit_err
);

    localparam int XW = no_of_digits * radix_bits;
    localparam int CW = (no_of_digits > 2) ? $clog2(no_of_digits) : 1;
    localparam int DW = radix_bits + 1;
    localparam int DMAX = radix - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_TOP = CW'(no_of_digits - 1);
    localparam logic [radix_bits-1:0] MIN_PAT =
        {1'b1, {(radix_bits-1){1'b0}}};
    localparam logic [DW-1:0] DMAX_V = DMAX[DW-1:0];

    logic [1:0]    state;
    logic [XW-1:0] x_q;
    logic          neg_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q;
    logic [W-1:0]  qm;
    logic          err;

    logic [radix_bits-1:0] digs [no_of_digits];
    logic [radix_bits-1:0] raw;
    logic signed [DW-1:0]  ext;
    logic signed [DW-1:0]  dv;
    logic signed [DW-1:0]  dm1;
    logic [DW-1:0]         mag;
    logic                  illegal;
    logic                  dig_pos;
    logic                  dig_neg;
    logic                  dig_zero;
    logic [log_radix-1:0]  lo_d;
    logic [log_radix-1:0]  lo_dm1;
    logic [W-1:0]          q_nxt;
    logic [W-1:0]          qm_nxt;
    logic                  err_nxt;
    logic                  accept;
    logic                  last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (cnt == '0);

    // Split the captured vector into its individual digits.
    always_comb begin
        for (int i = 0; i < no_of_digits; i++) begin
            digs[i] = x_q[i*radix_bits +: radix_bits];
        end
    end

    // Current digit: optional negation, legality check and low-bit fills.
    always_comb begin
        raw     = digs[cnt];
        ext     = $signed({raw[radix_bits-1], raw});
        dv      = neg_q ? -ext : ext;
        mag     = dv[DW-1] ? DW'(-dv) : DW'(dv);
        illegal = (raw == MIN_PAT) || (mag > DMAX_V);
        dm1     = dv - DW'(1);
        lo_d    = dv[log_radix-1:0];
        lo_dm1  = dm1[log_radix-1:0];
        dig_pos  = !illegal && !dv[DW-1] && (dv != '0);
        dig_neg  = !illegal && dv[DW-1];
        dig_zero = illegal || (dv == '0);
    end

    // On-the-fly Q/QM update: shift by log_radix and append low digits.
    always_comb begin
        q_nxt   = q;
        qm_nxt  = qm;
        err_nxt = err | illegal;
        unique case (1'b1)
            dig_pos: begin
                q_nxt  = {q[W-log_radix-1:0], lo_d};
                qm_nxt = {q[W-log_radix-1:0], lo_dm1};
            end
            dig_neg: begin
                q_nxt  = {qm[W-log_radix-1:0], lo_d};
                qm_nxt = {qm[W-log_radix-1:0], lo_dm1};
            end
            dig_zero: begin
                q_nxt  = {q[W-log_radix-1:0], {log_radix{1'b0}}};
                qm_nxt = {qm[W-log_radix-1:0], {log_radix{1'b1}}};
            end
        endcase
    end

    // Control FSM: accept, walk n digits, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state <= CONV;
                CONV:    if (last) state <= DONE;
                DONE:    if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Input capture and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            neg_q <= 1'b0;
            cnt   <= CNT_TOP;
        end else if (accept) begin
            x_q   <= x_in;
            neg_q <= in_neg;
            cnt   <= CNT_TOP;
        end else if (state == CONV && !last) begin
            cnt   <= cnt - CW'(1);
        end
    end

    // Conversion registers, reinitialised on every accepted vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            qm  <= '1;
            err <= 1'b0;
        end else if (accept) begin
            q   <= '0;
            qm  <= '1;
            err <= 1'b0;
        end else if (state == CONV) begin
            q   <= q_nxt;
            qm  <= qm_nxt;
            err <= err_nxt;
        end
    end

    // Output registers update only when the last digit is folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            digit_err <= 1'b0;
        end else if (state == CONV && last) begin
            result    <= q_nxt;
            digit_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_online_to_binary.sv
// tb_online_to_binary: table vectors, corner sequences and random
// vectors checked against an arithmetic model of the digit value.
module tb_online_to_binary;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] x_in;
    logic        in_neg;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  result;
    logic        digit_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    online_to_binary dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .digit_err (digit_err)
    );

    typedef struct {
        logic [11:0] x;
        logic        neg;
        logic [9:0]  res;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] pack(input int d3, input int d2,
                                         input int d1, input int d0);
        logic [2:0] a, b, c, d;
        a = 3'(d3);
        b = 3'(d2);
        c = 3'(d1);
        d = 3'(d0);
        return {a, b, c, d};
    endfunction

    // Reference: value = sum d_i * 4^i, illegal digit (-4) counts as 0.
    task automatic model(input logic [11:0] x, input logic neg,
                         output logic [9:0] res, output logic err);
        int val;
        int d;
        logic [2:0] f;
        logic [31:0] v32;
        val = 0;
        err = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            f = x[i*3 +: 3];
            d = int'($signed(f));
            if (d < -3 || d > 3) begin
                err = 1'b1;
                d = 0;
            end
            val = val * 4 + d;
        end
        if (neg) val = -val;
        v32 = 32'(val);
        res = v32[9:0];
    endtask

    task automatic run_vec(input logic [11:0] x, input logic neg,
                           input int hold, output logic [9:0] r,
                           output logic e, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x_in = x;
        in_neg = neg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in = 12'($urandom);
        in_neg = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        r = result;
        e = digit_err;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        chk("result_held", 32'(result), 32'(r));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_take", 32'(in_ready), 32'd1);
        chk("out_valid_after_take", 32'(out_valid), 32'd0);
    endtask

    vec_t        tbl[9];
    logic [9:0]  r;
    logic        e;
    logic [9:0]  er;
    logic        ee;
    int          lat;
    logic [11:0] rx;
    logic        rn;

    initial begin
        tbl[0] = '{pack(1, 0, 0, 0),   1'b0, 10'h040, 1'b0};
        tbl[1] = '{pack(0, 0, 0, -1),  1'b0, 10'h3FF, 1'b0};
        tbl[2] = '{pack(3, 3, 3, 3),   1'b0, 10'h0FF, 1'b0};
        tbl[3] = '{pack(-3, -3, -3, -3), 1'b0, 10'h301, 1'b0};
        tbl[4] = '{pack(1, -3, 2, 0),  1'b0, 10'h018, 1'b0};
        tbl[5] = '{pack(1, -3, 2, 0),  1'b1, 10'h3E8, 1'b0};
        tbl[6] = '{pack(0, 0, -4, 1),  1'b0, 10'h001, 1'b1};
        tbl[7] = '{pack(0, 0, 0, 2),   1'b0, 10'h002, 1'b0};
        tbl[8] = '{pack(0, 0, -4, 1),  1'b1, 10'h3FF, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        x_in = '0;
        in_neg = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_digit_err", 32'(digit_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i].x, tbl[i].neg, i % 3, r, e, lat);
            chk($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
        end

        // Backpressure: hold DONE five cycles with stray in_valid pulses.
        in_valid = 1'b1;
        x_in = pack(3, 3, 3, 3);
        in_neg = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'(k % 2 == 0);
            x_in = 12'($urandom);
            @(posedge clk);
            #1;
            chk("bp_result", 32'(result), 32'h0FF);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
        chk("bp_out_valid_fall", 32'(out_valid), 32'd0);
        chk("bp_result_idle", 32'(result), 32'h0FF);

        // Reset during the second CONV cycle aborts the vector.
        in_valid = 1'b1;
        x_in = pack(3, 2, 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        run_vec(pack(0, 1, 0, 0), 1'b0, 0, r, e, lat);
        chk("post_rst_result", 32'(r), 32'd16);
        chk("post_rst_latency", 32'(lat), 32'd4);

        // Random vectors against the arithmetic model.
        for (int t = 0; t < 60; t++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 9) == 0) rx[j*3 +: 3] = 3'b100;
                else rx[j*3 +: 3] = 3'($urandom_range(0, 6) - 3);
            end
            rn = 1'($urandom);
            model(rx, rn, er, ee);
            run_vec(rx, rn, int'($urandom_range(0, 2)), r, e, lat);
            chk($sformatf("rnd%0d_result x=%h n=%0d", t, rx, rn),
                32'(r), 32'(er));
            chk($sformatf("rnd%0d_err", t), 32'(e), 32'(ee));
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/online_to_binary.md
# online_to_binary

Digit-serial on-the-fly converter that sits directly downstream of the per-digit negation stage. It accepts one packed signed-digit vector (redundant, high-radix, same packing the negation stage emits), optionally negates it, and walks the digits MSD-first, one per clock, using on-the-fly conversion (Q/QM registers, no carry propagation). It presents the equivalent two's-complement integer on a valid/ready output.

## Interface
- no_of_digits, 4, digits per vector (n ≥ 2)
- radix_bits, 3, bits per signed digit (two's complement)
- radix, 4, radix r, a power of two; legal digit set is {-(r-1) .. r-1}
- log_radix, 2, log2(radix)
- Derived: W = no_of_digits*log_radix + 2, the result width (10 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  x_in and in_neg valid
- in_ready  out  1  block can accept a vector
- x_in  in  no_of_digits*radix_bits  digit i at [(i+1)*radix_bits-1 : i*radix_bits]; digit 0 is LSD; value = Σ d_i·r^i
- in_neg  in  1  convert −x_in instead of x_in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  two's-complement value
- digit_err  out  1  at least one illegal digit in this vector

## Operation
- FSM states: IDLE, CONV, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid=1 (accept edge):
  - capture x_in and in_neg
  - set Q=0, QM=all-ones (−1), err=0, digit counter=n−1
  - go to CONV
- CONV: each cycle take digit d = digit[counter]. If in_neg=1, d := −d.
  - Illegal digit: raw pattern equal to −2^(radix_bits−1), or |d| > r−1. It is processed as d=0 and sets err.
  - d>0: Q←Q·r+d, QM←Q·r+(d−1)
  - d=0: Q←Q·r, QM←QM·r+(r−1)
  - d<0: Q←QM·r+(r+d), QM←QM·r+(r+d−1)
  - ·r is a left shift by log_radix. The low log_radix bits are filled by concatenation. Width is W, modulo 2^W, with no adders on Q/QM.
  - After processing digit 0: copy Q to result, copy err to digit_err, go to DONE.
- DONE: result and digit_err are held stable. On out_ready=1, go to IDLE.
- result and digit_err change only on entry to DONE. They hold their last values in IDLE and CONV.
- Range: |value| ≤ (r−1)(r^n−1)/(r−1), which always fits in W bits. No overflow is possible for legal digits.

## Timing
- Reset (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, result=0, digit_err=0, Q=0, QM=−1, counter=n−1.
- Reset mid-CONV or in DONE aborts the vector. The captured vector is discarded and no output is produced.
- Latency: accept at edge k. out_valid rises after edge k+n and is first sampled high at edge k+n+1.
- Throughput: one vector per n+2 cycles minimum (accept cycle, n CONV cycles, ≥1 DONE cycle).
- in_ready=0 throughout CONV and DONE. in_valid in those states is ignored and x_in is not sampled.
- DONE with out_ready=1: go to IDLE at that edge. A new vector can be accepted no earlier than the next edge; there is no same-cycle pass-through.
- out_ready held low: DONE is held indefinitely, and result and digit_err do not change.
- x_in and in_neg may change freely after the accept edge.

## Test plan
- Digits (MSD→LSD) 1,0,0,0, in_neg=0 → result=64 (10'h040), digit_err=0, out_valid at accept+5 edges.
- 0,0,0,−1 → result=10'h3FF (−1). Then 3,3,3,3 → 255 (10'h0FF). Then −3,−3,−3,−3 → −255 (10'h301).
- 1,−3,2,0 with in_neg=0 → 24 (10'h018). Same vector with in_neg=1 → −24 (10'h3E8).
- Illegal digit: 0,0,−4,1 → result=1, digit_err=1. The next legal vector 0,0,0,2 → result=2, digit_err=0.
- Backpressure: out_ready held low 5 cycles in DONE.
  - result is stable, in_ready=0, and in_valid pulses are ignored.
  - out_ready=1 → IDLE on the next edge, and in_ready rises.
- Reset mid-CONV: assert rst_n low during the 2nd CONV cycle → out_valid=0, result=0, in_ready=1. A following vector 0,1,0,0 converts to 16 with normal latency.
